jacaranda_flash_loader: RTL and testbench

Boot sequencer for the jacaranda-8 core inside the Caravel user area. It holds the CPU in reset and issues a single SPI READ (0x03) burst to an external SPI flash. Each returned byte is written into the core's 8-bit instruction memory at consecutive addresses. When the burst completes it releases the CPU.

---
 rtl/jacaranda_flash_loader.sv | 213 +++++++++++++++++++++
 tb/tb_jacaranda_flash_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jacaranda_flash_loader.sv
// jacaranda_flash_loader
// Boot sequencer for the jacaranda-8 core. Holds the CPU in reset, issues one SPI READ (0x03)
// burst to an external flash (mode 0, MSB first) and writes each returned byte into the
// 8-bit instruction memory at consecutive addresses, then releases the CPU.
//
// Ports:
//   wb_clk_i      system clock, all logic on the rising edge
//   wb_rst_i      synchronous active-high reset
//   start_i       single-cycle load request (accepted in IDLE or DONE)
//   busy_o        load in progress
//   done_o        load complete, CPU released
//   cpu_rst_o     core reset, low only in DONE
//   spi_csb_o     flash chip select (active low)
//   spi_sck_o     flash SPI clock
//   spi_mosi_o    command/address to flash
//   spi_miso_i    data from flash
//   imem_we_o     instruction-memory write strobe (one-cycle pulse)
//   imem_addr_o   instruction-memory write address
//   imem_wdata_o  instruction-memory write data
module jacaranda_flash_loader #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned LOAD_LEN   = 256,
    parameter logic [23:0] FLASH_BASE = 24'h000000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              cpu_rst_o,
    output logic              spi_csb_o,
    output logic              spi_sck_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [7:0]        imem_wdata_o
);

    localparam int unsigned TOTAL_BITS = 32 + 8 * LOAD_LEN;
    localparam int unsigned CNT_W      = $clog2(TOTAL_BITS + 1);

    localparam logic [7:0]       READ_CMD  = 8'h03;
    localparam logic [7:0]       DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(31);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(TOTAL_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StFinish,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        div_q, div_d;
    logic              sck_q, sck_d;
    logic              csb_q, csb_d;
    logic              mosi_q, mosi_d;
    logic [31:0]       tx_q, tx_d;
    logic [CNT_W-1:0]  bit_q, bit_d;
    logic [7:0]        rx_q, rx_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cpu_rst_q, cpu_rst_d;

    logic       active;
    logic       tick;
    logic       rise;
    logic       fall;
    logic       start_ok;
    logic [7:0] rx_byte;

    assign active   = (state_q == StCmd) || (state_q == StAddr) || (state_q == StData);
    assign tick     = active && (div_q == DIV_LAST);
    assign rise     = tick && !sck_q;
    assign fall     = tick && sck_q;
    assign start_ok = start_i && ((state_q == StIdle) || (state_q == StDone));
    assign rx_byte  = {rx_q[6:0], spi_miso_i};

    // State register and all datapath flops
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= StIdle;
            div_q     <= '0;
            sck_q     <= 1'b0;
            csb_q     <= 1'b1;
            mosi_q    <= 1'b0;
            tx_q      <= '0;
            bit_q     <= '0;
            rx_q      <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            sck_q     <= sck_d;
            csb_q     <= csb_d;
            mosi_q    <= mosi_d;
            tx_q      <= tx_d;
            bit_q     <= bit_d;
            rx_q      <= rx_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    // Next-state logic; phase ends are taken on the SCK fall that completes the phase
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start_i) state_d = StCmd;
            StCmd:    if (fall && (bit_q == CMD_LAST)) state_d = StAddr;
            StAddr:   if (fall && (bit_q == ADDR_LAST)) state_d = StData;
            StData:   if (fall && (bit_q == DATA_LAST)) state_d = StFinish;
            StFinish: if (csb_q) state_d = StDone;
            StDone:   if (start_i) state_d = StCmd;
            default:  state_d = StIdle;
        endcase
    end

    // Status outputs, registered from the next state so they change on the entering edge
    always_comb begin
        busy_d    = (state_d != StIdle) && (state_d != StDone);
        done_d    = (state_d == StDone);
        cpu_rst_d = (state_d != StDone);
    end

    // SPI shifter, clock divider and memory write path
    always_comb begin
        div_d   = div_q;
        sck_d   = sck_q;
        csb_d   = csb_q;
        mosi_d  = mosi_q;
        tx_d    = tx_q;
        bit_d   = bit_q;
        rx_d    = rx_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        if (start_ok) begin
            div_d  = '0;
            sck_d  = 1'b0;
            csb_d  = 1'b0;
            // First bit goes out on the start edge; tx holds the remaining 31 bits.
            mosi_d = READ_CMD[7];
            tx_d   = {READ_CMD[6:0], FLASH_BASE, 1'b0};
            bit_d  = '0;
            rx_d   = '0;
            idx_d  = '0;
        end else if (active) begin
            if (tick) begin
                div_d = '0;
                sck_d = ~sck_q;
            end else begin
                div_d = div_q + 8'd1;
            end
            if (rise && (state_q == StData)) begin
                rx_d = rx_byte;
                // 32 header bits keep bit_q[2:0] aligned with the bit-in-byte position.
                if (bit_q[2:0] == 3'd7) begin
                    we_d    = 1'b1;
                    wdata_d = rx_byte;
                    addr_d  = idx_q;
                    idx_d   = idx_q + ADDR_W'(1);
                end
            end
            if (fall) begin
                bit_d  = bit_q + CNT_W'(1);
                mosi_d = tx_q[31];
                tx_d   = {tx_q[30:0], 1'b0};
            end
        end else if ((state_q == StFinish) && !csb_q) begin
            // Hold CSB low for CLK_DIV cycles after the last SCK fall.
            if (div_q == DIV_LAST) begin
                csb_d = 1'b1;
                div_d = '0;
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign cpu_rst_o    = cpu_rst_q;
    assign spi_csb_o    = csb_q;
    assign spi_sck_o    = sck_q;
    assign spi_mosi_o   = mosi_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;

endmodule

// File: tb/tb_jacaranda_flash_loader.sv
// Testbench for jacaranda_flash_loader. Two instances: instance 0 (CLK_DIV=2, ADDR_W=8,
// LOAD_LEN=4, base 0) and instance 1 (CLK_DIV=1, ADDR_W=3, LOAD_LEN=8, base 0x100), each
// driven by a behavioural SPI flash and checked against the expected load image.
module tb_jacaranda_flash_loader;

    localparam int unsigned CD0 = 2, AW0 = 8, LEN0 = 4;
    localparam int unsigned CD1 = 1, AW1 = 3, LEN1 = 8;
    localparam logic [23:0] BASE0 = 24'h000000;
    localparam logic [23:0] BASE1 = 24'h000100;
    localparam int FLASH_SZ = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst, start, miso;
    logic [1:0] busy, done, cpu_rst, csb, sck, mosi, we;
    logic [AW0-1:0] addr0;
    logic [AW1-1:0] addr1;
    logic [7:0] wdata0, wdata1;
    logic [7:0] addr_w [2];
    logic [7:0] wdata_w [2];

    int n_tests = 0;
    int n_fail  = 0;

    jacaranda_flash_loader #(
        .CLK_DIV(CD0), .ADDR_W(AW0), .LOAD_LEN(LEN0), .FLASH_BASE(BASE0)
    ) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst[0]), .start_i(start[0]), .busy_o(busy[0]),
        .done_o(done[0]), .cpu_rst_o(cpu_rst[0]), .spi_csb_o(csb[0]), .spi_sck_o(sck[0]),
        .spi_mosi_o(mosi[0]), .spi_miso_i(miso[0]), .imem_we_o(we[0]),
        .imem_addr_o(addr0), .imem_wdata_o(wdata0)
    );

    jacaranda_flash_loader #(
        .CLK_DIV(CD1), .ADDR_W(AW1), .LOAD_LEN(LEN1), .FLASH_BASE(BASE1)
    ) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst[1]), .start_i(start[1]), .busy_o(busy[1]),
        .done_o(done[1]), .cpu_rst_o(cpu_rst[1]), .spi_csb_o(csb[1]), .spi_sck_o(sck[1]),
        .spi_mosi_o(mosi[1]), .spi_miso_i(miso[1]), .imem_we_o(we[1]),
        .imem_addr_o(addr1), .imem_wdata_o(wdata1)
    );

    always_comb begin
        addr_w[0]  = addr0;
        addr_w[1]  = {5'b0, addr1};
        wdata_w[0] = wdata0;
        wdata_w[1] = wdata1;
    end

    function automatic int cd_of(input int sel);
        return (sel == 0) ? CD0 : CD1;
    endfunction
    function automatic int len_of(input int sel);
        return (sel == 0) ? LEN0 : LEN1;
    endfunction
    function automatic int aw_of(input int sel);
        return (sel == 0) ? AW0 : AW1;
    endfunction
    function automatic logic [23:0] base_of(input int sel);
        return (sel == 0) ? BASE0 : BASE1;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flash contents and monitor state (written only by the monitor process below)
    logic [7:0]  flash_mem [FLASH_SZ];
    int          rcnt [2]        = '{default: 0};
    logic [31:0] cmd_sh [2]      = '{default: 0};
    logic [31:0] frame_cmd [2]   = '{default: 0};
    int          frame_rises [2] = '{default: 0};
    int          frame_cnt [2]   = '{default: 0};
    int          wr_cnt [2]      = '{default: 0};
    logic [7:0]  wr_addr [2][256];
    logic [7:0]  wr_data [2][256];
    int          err_half [2]    = '{default: 0};
    int          err_pulse [2]   = '{default: 0};
    int          err_align [2]   = '{default: 0};
    int          err_rel [2]     = '{default: 0};
    int          since [2]       = '{default: 0};
    logic [1:0]  sck_p = '0, csb_p = '1, we_p = '0;

    // Flash drives the bit for the next SCK rise; the byte index follows the captured address.
    always_comb begin
        miso = '0;
        for (int i = 0; i < 2; i++) begin
            if (rcnt[i] >= 32)
                miso[i] = flash_mem[(int'(cmd_sh[i][23:0]) + (rcnt[i] - 32) / 8) % FLASH_SZ]
                                   [7 - ((rcnt[i] - 32) % 8)];
        end
    end

    // Bus monitor and flash command capture, sampled on the falling clock edge
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (csb_p[i] === 1'b1 && csb[i] === 1'b0) begin
                    rcnt[i]   = 0;
                    cmd_sh[i] = '0;
                    since[i]  = 0;
                end else if (csb_p[i] === 1'b0) begin
                    since[i]++;
                    if (sck[i] !== sck_p[i] || csb[i] === 1'b1) begin
                        if (since[i] != cd_of(i) && rst[i] !== 1'b1) err_half[i]++;
                        since[i] = 0;
                    end
                    if (sck[i] === 1'b1 && sck_p[i] === 1'b0) begin
                        if (rcnt[i] < 32) cmd_sh[i] = {cmd_sh[i][30:0], mosi[i]};
                        rcnt[i]++;
                    end
                    if (csb[i] === 1'b1) begin
                        frame_cmd[i]   = cmd_sh[i];
                        frame_rises[i] = rcnt[i];
                        frame_cnt[i]++;
                        rcnt[i] = 0;
                    end
                end
                if (we[i] === 1'b1) begin
                    if (we_p[i] === 1'b1) err_pulse[i]++;
                    if (!(sck[i] === 1'b1 && sck_p[i] === 1'b0)) err_align[i]++;
                    wr_addr[i][wr_cnt[i] % 256] = addr_w[i];
                    wr_data[i][wr_cnt[i] % 256] = wdata_w[i];
                    wr_cnt[i]++;
                end
                if (cpu_rst[i] === 1'b0 && done[i] !== 1'b1) err_rel[i]++;
                if (busy[i] === 1'b1 && done[i] === 1'b1) err_rel[i]++;
                sck_p[i] = sck[i];
                csb_p[i] = csb[i];
                we_p[i]  = we[i];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input int sel);
        start[sel] = 1'b1;
        @(negedge clk);
        start[sel] = 1'b0;
    endtask

    task automatic randomize_flash();
        for (int a = 0; a < FLASH_SZ; a++) flash_mem[a] = 8'($urandom);
    endtask

    task automatic wait_done(input int sel, input int budget);
        int n = 0;
        while (done[sel] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val($sformatf("done_in_time[%0d]", sel), 64'(done[sel]), 64'd1);
    endtask

    // Full load with optional start pulses while busy; checks image, frame and timing rules.
    task automatic run_load(input int sel, input bit spam);
        int w0 = wr_cnt[sel];
        int f0 = frame_cnt[sel];
        int e0 = err_half[sel] + err_pulse[sel] + err_align[sel] + err_rel[sel];
        int len = len_of(sel);
        int k;
        logic [23:0] base = base_of(sel);
        pulse_start(sel);
        check_val($sformatf("start_busy[%0d]", sel), 64'(busy[sel]), 64'd1);
        check_val($sformatf("start_csb[%0d]", sel), 64'(csb[sel]), 64'd0);
        check_val($sformatf("start_cpurst[%0d]", sel), 64'(cpu_rst[sel]), 64'd1);
        check_val($sformatf("start_done[%0d]", sel), 64'(done[sel]), 64'd0);
        check_val($sformatf("start_sck[%0d]", sel), 64'(sck[sel]), 64'd0);
        if (spam) begin
            repeat (5) begin
                tick($urandom_range(5, 20));
                if (busy[sel] === 1'b1) pulse_start(sel);
            end
        end
        wait_done(sel, 3000);
        check_val($sformatf("done_busy[%0d]", sel), 64'(busy[sel]), 64'd0);
        check_val($sformatf("done_cpurst[%0d]", sel), 64'(cpu_rst[sel]), 64'd0);
        check_val($sformatf("done_csb[%0d]", sel), 64'(csb[sel]), 64'd1);
        check_val($sformatf("frames[%0d]", sel), 64'(frame_cnt[sel] - f0), 64'd1);
        check_val($sformatf("cmd_addr[%0d]", sel), 64'(frame_cmd[sel]), 64'({8'h03, base}));
        check_val($sformatf("sck_rises[%0d]", sel), 64'(frame_rises[sel]), 64'(32 + 8 * len));
        check_val($sformatf("writes[%0d]", sel), 64'(wr_cnt[sel] - w0), 64'(len));
        for (k = 0; k < len; k++) begin
            check_val($sformatf("wr_addr[%0d][%0d]", sel, k), 64'(wr_addr[sel][(w0 + k) % 256]),
                      64'(k % (1 << aw_of(sel))));
            check_val($sformatf("wr_data[%0d][%0d]", sel, k), 64'(wr_data[sel][(w0 + k) % 256]),
                      64'(flash_mem[(int'(base) + k) % FLASH_SZ]));
        end
        check_val($sformatf("hold_addr[%0d]", sel), 64'(addr_w[sel]),
                  64'((len - 1) % (1 << aw_of(sel))));
        check_val($sformatf("hold_wdata[%0d]", sel), 64'(wdata_w[sel]),
                  64'(flash_mem[(int'(base) + len - 1) % FLASH_SZ]));
        check_val($sformatf("protocol_errs[%0d]", sel),
                  64'(err_half[sel] + err_pulse[sel] + err_align[sel] + err_rel[sel] - e0), 64'd0);
    endtask

    initial begin
        int n;
        int w0;
        rst   = 2'b11;
        start = 2'b00;
        randomize_flash();
        flash_mem[0] = 8'hA5;
        flash_mem[1] = 8'h3C;
        flash_mem[2] = 8'hFF;
        flash_mem[3] = 8'h00;
        tick(3);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("rst_busy[%0d]", i), 64'(busy[i]), 64'd0);
            check_val($sformatf("rst_done[%0d]", i), 64'(done[i]), 64'd0);
            check_val($sformatf("rst_cpurst[%0d]", i), 64'(cpu_rst[i]), 64'd1);
            check_val($sformatf("rst_csb[%0d]", i), 64'(csb[i]), 64'd1);
            check_val($sformatf("rst_sck[%0d]", i), 64'(sck[i]), 64'd0);
            check_val($sformatf("rst_mosi[%0d]", i), 64'(mosi[i]), 64'd0);
            check_val($sformatf("rst_we[%0d]", i), 64'(we[i]), 64'd0);
            check_val($sformatf("rst_addr[%0d]", i), 64'(addr_w[i]), 64'd0);
            check_val($sformatf("rst_wdata[%0d]", i), 64'(wdata_w[i]), 64'd0);
        end
        rst = 2'b00;
        tick(2);

        // Basic load (A5 3C FF 00), then a reload from DONE with ignored start pulses
        run_load(0, 1'b0);
        tick(5);
        check_val("done_hold[0]", 64'(done[0]), 64'd1);
        randomize_flash();
        run_load(0, 1'b1);

        // Offset base, SCK period 2, 8-entry address space wrapping back to 0 on reload
        run_load(1, 1'b0);
        run_load(1, 1'b1);

        // Reset during the second data byte
        w0 = wr_cnt[0];
        pulse_start(0);
        n = 0;
        while (rcnt[0] < 43 && n < 1000) begin
            tick(1);
            n++;
        end
        check_val("reached_byte2", 64'(rcnt[0] >= 43), 64'd1);
        rst[0] = 1'b1;
        @(negedge clk);
        check_val("midrst_csb", 64'(csb[0]), 64'd1);
        check_val("midrst_sck", 64'(sck[0]), 64'd0);
        check_val("midrst_cpurst", 64'(cpu_rst[0]), 64'd1);
        check_val("midrst_busy", 64'(busy[0]), 64'd0);
        check_val("midrst_done", 64'(done[0]), 64'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        tick(80);
        check_val("midrst_writes", 64'(wr_cnt[0] - w0), 64'd1);
        check_val("midrst_idle_csb", 64'(csb[0]), 64'd1);
        randomize_flash();
        run_load(0, 1'b0);

        // Randomised reloads on both instances
        for (int r = 0; r < 3; r++) begin
            randomize_flash();
            run_load(0, r[0]);
            run_load(1, ~r[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
